key_filter: RTL and testbench

Input-side companion to the LED drivers: debounces N active-low push-buttons sampled on `sys_clk` and turns them into a clean per-key pressed level plus single-cycle press, release and (optionally) long-press strobes. It sits between board pins and the pattern/control logic that drives the LEDs. Each key is handled by an independent channel; channels share no state.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_filter_ch.sv | 127 ++++++++++++
 rtl/key_filter.sv | 34 +++
 tb/tb_key_filter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared types and default timing for the key filter.
// Defaults assume a 50 MHz sys_clk (20 ms debounce, 1 s long press).
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    REL_FILT
  } key_st_e;

  localparam int KEY_DEBOUNCE_DEF = 1_000_000;
  localparam int KEY_LONG_DEF     = 50_000_000;

endpackage

// File: rtl/key_filter_ch.sv
// key_filter_ch: one key channel - 2-flop synchronizer, debounce FSM,
// optional long-press counter (KEY_FILTER_LONG_EN). Ports: sys_clk,
// sys_rst_n, key (raw, active-low) -> key_level/press/release/long.
module key_filter_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = KEY_DEBOUNCE_DEF,
  parameter int LONG_CNT     = KEY_LONG_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = (DEBOUNCE_CNT > 2) ?
                      $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  key_st_e       st;
  logic [CW-1:0] cnt;

  // Pins idle high, so the synchronizer resets to "released".
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

`ifdef KEY_FILTER_LONG_EN
  localparam int LW = $clog2(LONG_CNT + 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CNT);
  localparam logic [LW-1:0] L_FIRE = LW'(LONG_CNT - 1);
  logic [LW-1:0] lcnt;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st          <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_FILTER_LONG_EN
      lcnt        <= '0;
      key_long    <= 1'b0;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_FILTER_LONG_EN
      key_long    <= 1'b0;
      // Saturating hold timer; fires once as it steps
      // from LONG_CNT-1 to LONG_CNT.
      if (st == DOWN || st == REL_FILT) begin
        if (lcnt == L_FIRE) key_long <= 1'b1;
        if (lcnt != L_MAX) lcnt <= lcnt + LW'(1);
      end
`endif
      unique case (st)
        IDLE: begin
          if (s) begin
            st  <= PRESS_FILT;
            cnt <= '0;
          end
        end
        PRESS_FILT: begin
          if (!s) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            st        <= DOWN;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
`ifdef KEY_FILTER_LONG_EN
            lcnt      <= '0;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DOWN: begin
          if (!s) begin
            st  <= REL_FILT;
            cnt <= '0;
          end
        end
        REL_FILT: begin
          // Bounce back to DOWN keeps the hold timer running.
          if (s) begin
            st  <= DOWN;
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            st          <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

`ifndef KEY_FILTER_LONG_EN
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_filter.sv
// key_filter: N_KEY independent debounced push-button channels.
// Long-press strobe built only with KEY_FILTER_LONG_EN defined.
module key_filter
  import key_pkg::*;
#(
  parameter int N_KEY        = 2,
  parameter int DEBOUNCE_CNT = KEY_DEBOUNCE_DEF,
  parameter int LONG_CNT     = KEY_LONG_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_KEY-1:0] key,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_long
);

  for (genvar i = 0; i < N_KEY; i++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .LONG_CNT    (LONG_CNT)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed checks of key_filter with
// DEBOUNCE_CNT=8, LONG_CNT=32, N_KEY=2.
module tb_key_filter;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] key;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_long;

`ifdef KEY_FILTER_LONG_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  int n_chk;
  int n_fail;
  int n_press [2];
  int n_rel   [2];
  int n_long  [2];
  int n_lvl0;

  key_filter #(
    .N_KEY       (2),
    .DEBOUNCE_CNT(8),
    .LONG_CNT    (32)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    n_press = '{0, 0};
    n_rel   = '{0, 0};
    n_long  = '{0, 0};
    n_lvl0  = 0;
  end

  always @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (key_press[i])   n_press[i]++;
      if (key_release[i]) n_rel[i]++;
      if (key_long[i])    n_long[i]++;
    end
    if (key_level[0]) n_lvl0++;
  end

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  int b_press0, b_press1, b_rel0, b_rel1;
  int b_long0, b_long1, b_lvl;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    sys_rst_n = 1'b0;
    key       = 2'b11;
    step(3);
    check("rst_level", int'(key_level), 0);
    check("rst_press", int'(key_press), 0);
    check("rst_rel", int'(key_release), 0);
    check("rst_long", int'(key_long), 0);
    sys_rst_n = 1'b1;
    step(3);

    // Clean press/release on key[0]
    key[0] = 1'b0;
    step(10);
    check("press_early", int'(key_press), 0);
    step(1);
    check("press0", int'(key_press), 1);
    check("level0_up", int'(key_level), 1);
    step(1);
    check("press0_1cyc", int'(key_press), 0);
    step(8);
    key[0] = 1'b1;
    step(10);
    check("rel_early", int'(key_release), 0);
    check("level0_held", int'(key_level), 1);
    step(1);
    check("rel0", int'(key_release), 1);
    check("level0_down", int'(key_level), 0);
    step(1);
    check("rel0_1cyc", int'(key_release), 0);

    // Bounce on key[0]
    b_press0 = n_press[0];
    b_rel0   = n_rel[0];
    b_lvl    = n_lvl0;
    key[0] = 1'b0; step(5);
    key[0] = 1'b1; step(3);
    key[0] = 1'b0; step(5);
    key[0] = 1'b1; step(20);
    check("bnc_press", n_press[0] - b_press0, 0);
    check("bnc_rel", n_rel[0] - b_rel0, 0);
    check("bnc_level", n_lvl0 - b_lvl, 0);

    // Long hold on key[1]
    b_press1 = n_press[1];
    b_rel1   = n_rel[1];
    b_long1  = n_long[1];
    key[1] = 1'b0;
    step(11);
    check("press1", int'(key_press), 2);
    step(31);
    check("long1_early", int'(key_long), 0);
    step(1);
    check("long1", int'(key_long), LONG_EN ? 2 : 0);
    step(1);
    check("long1_1cyc", int'(key_long), 0);
    step(15);
    key[1] = 1'b1;
    step(11);
    check("rel1", int'(key_release), 2);
    step(5);
    check("long1_cnt", n_long[1] - b_long1, LONG_EN ? 1 : 0);
    check("rel1_cnt", n_rel[1] - b_rel1, 1);
    check("press1_cnt", n_press[1] - b_press1, 1);

    // Release glitch on key[0] during a hold
    b_rel0  = n_rel[0];
    b_long0 = n_long[0];
    key[0] = 1'b0;
    step(11);
    check("press0_g", int'(key_press), 1);
    step(5);
    key[0] = 1'b1; step(4);
    key[0] = 1'b0; step(13);
    check("glitch_level", int'(key_level), 1);
    check("glitch_rel", n_rel[0] - b_rel0, 0);
    step(9);
    check("long0_early", int'(key_long), 0);
    step(1);
    check("long0", int'(key_long), LONG_EN ? 1 : 0);
    step(5);
    key[0] = 1'b1;
    step(11);
    check("rel0_g", int'(key_release), 1);
    check("long0_cnt", n_long[0] - b_long0, LONG_EN ? 1 : 0);
    step(3);

    // Both keys in the same cycle
    key = 2'b00;
    step(11);
    check("press_both", int'(key_press), 3);
    check("level_both", int'(key_level), 3);
    key = 2'b11;
    step(11);
    check("rel_both", int'(key_release), 3);
    step(3);

    // Reset while key[0] held down
    key[0] = 1'b0;
    step(14);
    check("pre_rst_lvl", int'(key_level), 1);
    sys_rst_n = 1'b0;
    #1;
    check("arst_level", int'(key_level), 0);
    check("arst_strobe",
          int'(key_press | key_release | key_long), 0);
    step(2);
    sys_rst_n = 1'b1;
    step(10);
    check("rst_nopress", int'(key_press), 0);
    step(1);
    check("rst_repress", int'(key_press), 1);
    check("rst_relevel", int'(key_level), 1);
    key[0] = 1'b1;
    step(15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
